// File: rtl/board_run_controller.sv
// Board-level run/clock controller for the 16-bit stack CPU.
// Debounces the board buttons and derives phased one-cycle clock enables
// (cpu_ce, then mem_ce half a period later). A run/step/halt state machine,
// driven by the run button and the CPU's endProgram flag, gates those enables.
// Also provides a heartbeat LED field, a sticky end-of-program LED and a
// saturating count of issued CPU enables.
module board_run_controller #(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CE_DIV          = 4,
    parameter int CNT_W           = 32,
    parameter int HB_LSB          = 27,
    parameter int HB_BITS         = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               mode_step,
    input  logic               end_program,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic               cpu_ce,
    output logic               mem_ce,
    output logic [1:0]         state,
    output logic [15:0]        ce_count,
    output logic [HB_BITS-1:0] heartbeat,
    output logic               end_led
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DW = $clog2(CE_DIV);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] CPU_PH  = DW'(CE_DIV - 1);
    localparam logic [DW-1:0] MEM_PH  = DW'(CE_DIV / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // Button path
    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] pulse_q, pulse_d;
    logic [CW-1:0]      db_cnt_q [NUM_BTN];
    logic [CW-1:0]      db_cnt_d [NUM_BTN];

    // Phase divider, heartbeat and FSM
    logic [DW-1:0]    div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic             step_cpu_done_q, step_cpu_done_d;
    logic             halt_pend_q, halt_pend_d;
    logic             mem_owed_q, mem_owed_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             mem_ce_q, mem_ce_d;
    logic [15:0]      ce_count_q, ce_count_d;
    logic             end_led_q, end_led_d;

    logic run_pulse;
    logic raw_cpu;
    logic raw_mem;

    assign run_pulse = pulse_q[0];
    assign raw_cpu   = (div_q == CPU_PH);
    assign raw_mem   = (div_q == MEM_PH);

    // Debounce: count consecutive cycles where the synchronised input disagrees
    // with the accepted level; accept the new level on the last stable cycle.
    always_comb begin
        level_d = level_q;
        pulse_d = {NUM_BTN{1'b0}};
        for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_d[i] = {CW{1'b0}};
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i]  = sync2_q[i];
                    pulse_d[i]  = sync2_q[i];
                    db_cnt_d[i] = {CW{1'b0}};
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CW'(1);
                end
            end else begin
                db_cnt_d[i] = {CW{1'b0}};
            end
        end
    end

    // Free-running divider and heartbeat counter, plus sticky end LED.
    always_comb begin
        if (div_q == CPU_PH) begin
            div_d = {DW{1'b0}};
        end else begin
            div_d = div_q + DW'(1);
        end
        cnt_d     = cnt_q + CNT_W'(1);
        end_led_d = end_led_q | end_program;
    end

    // Run/step/halt FSM and enable gating. A cpu_ce always owes one mem_ce;
    // the owed mem_ce is paid at the next mem phase in any state but HALT,
    // so pausing never leaves a half-completed cycle behind.
    always_comb begin
        state_d         = state_q;
        step_cpu_done_d = step_cpu_done_q;
        halt_pend_d     = halt_pend_q;
        mem_owed_d      = mem_owed_q;
        cpu_ce_d        = 1'b0;
        mem_ce_d        = 1'b0;

        if ((state_q != ST_HALT) && raw_mem && mem_owed_q) begin
            mem_ce_d   = 1'b1;
            mem_owed_d = 1'b0;
        end else begin
            mem_ce_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                step_cpu_done_d = 1'b0;
                halt_pend_d     = 1'b0;
                if (run_pulse) begin
                    state_d = mode_step ? ST_STEP : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (raw_cpu) begin
                    cpu_ce_d   = 1'b1;
                    mem_owed_d = 1'b1;
                end else begin
                    cpu_ce_d   = 1'b0;
                end
                if (end_program) begin
                    state_d = ST_HALT;
                end else if (run_pulse) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                if (!step_cpu_done_q) begin
                    // Nothing of this step is in flight yet: halt at once.
                    if (end_program) begin
                        state_d = ST_HALT;
                    end else if (raw_cpu) begin
                        cpu_ce_d        = 1'b1;
                        mem_owed_d      = 1'b1;
                        step_cpu_done_d = 1'b1;
                    end else begin
                        state_d = ST_STEP;
                    end
                end else begin
                    // cpu_ce already issued: finish with its mem_ce first.
                    if (end_program) begin
                        halt_pend_d = 1'b1;
                    end else begin
                        halt_pend_d = halt_pend_q;
                    end
                    if (raw_mem && mem_owed_q) begin
                        step_cpu_done_d = 1'b0;
                        halt_pend_d     = 1'b0;
                        state_d = (halt_pend_q || end_program) ? ST_HALT : ST_IDLE;
                    end else begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cpu_ce_d && (ce_count_q != 16'hFFFF)) begin
            ce_count_d = ce_count_q + 16'd1;
        end else begin
            ce_count_d = ce_count_q;
        end
    end

    // Button synchronisers, debounce counters and accepted levels.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= {NUM_BTN{1'b0}};
            sync2_q <= {NUM_BTN{1'b0}};
            level_q <= {NUM_BTN{1'b0}};
            pulse_q <= {NUM_BTN{1'b0}};
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // Divider, heartbeat counter, FSM state and registered enables/counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div_q           <= {DW{1'b0}};
            cnt_q           <= {CNT_W{1'b0}};
            state_q         <= ST_IDLE;
            step_cpu_done_q <= 1'b0;
            halt_pend_q     <= 1'b0;
            mem_owed_q      <= 1'b0;
            cpu_ce_q        <= 1'b0;
            mem_ce_q        <= 1'b0;
            ce_count_q      <= 16'd0;
            end_led_q       <= 1'b0;
        end else begin
            div_q           <= div_d;
            cnt_q           <= cnt_d;
            state_q         <= state_d;
            step_cpu_done_q <= step_cpu_done_d;
            halt_pend_q     <= halt_pend_d;
            mem_owed_q      <= mem_owed_d;
            cpu_ce_q        <= cpu_ce_d;
            mem_ce_q        <= mem_ce_d;
            ce_count_q      <= ce_count_d;
            end_led_q       <= end_led_d;
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;
    assign cpu_ce    = cpu_ce_q;
    assign mem_ce    = mem_ce_q;
    assign state     = state_q;
    assign ce_count  = ce_count_q;
    assign heartbeat = cnt_q[HB_LSB +: HB_BITS];
    assign end_led   = end_led_q;

endmodule

// File: doc/board_run_controller.md
Name: board_run_controller

Overview:
- Synthesizable board-level run/clock controller for the 16-bit stack CPU.
- Debounces NUM_BTN raw buttons and generates phased single-cycle clock enables: cpu_ce for control/datapath registers, mem_ce for memory. This replaces delay-based memory clocking.
- Runs a run/step/halt state machine driven by the run button and the CPU's endProgram flag.
- Provides an LED heartbeat field, an end-of-program LED latch and an instruction-phase counter.

Parameters:
- NUM_BTN, 2: number of raw button inputs. Bit 0 is the run/step button.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a new button level. Minimum 1.
- CE_DIV, 4: cpu_ce period in CLK cycles. Must be even and at least 2.
- CNT_W, 32: width of the free-running heartbeat counter.
- HB_LSB, 27: lowest heartbeat counter bit routed to LEDs.
- HB_BITS, 5: number of heartbeat bits. HB_LSB+HB_BITS must not exceed CNT_W.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- btn_raw  input  NUM_BTN  raw, asynchronous button levels.
- mode_step  input  1  0 = free-run on run press; 1 = single-step on run press. Sampled only in IDLE.
- end_program  input  1  endProgram flag from the control unit.
- btn_level  output  NUM_BTN  debounced button levels.
- btn_pulse  output  NUM_BTN  one-cycle pulse on each debounced rising edge.
- cpu_ce  output  1  one-cycle clock enable for CPU registers.
- mem_ce  output  1  one-cycle clock enable for memory, half a period after cpu_ce.
- state  output  2  IDLE=0, RUN=1, STEP=2, HALT=3.
- ce_count  output  16  number of cpu_ce pulses issued. Saturates at 16'hFFFF.
- heartbeat  output  HB_BITS  equals cnt[HB_LSB +: HB_BITS].
- end_led  output  1  sticky copy of end_program.

Behaviour:
- Reset (asynchronous, RESET=1):
  - All outputs are 0 and state is IDLE.
  - The divider, heartbeat counter, debounce counters and synchronisers are all cleared.
  - Assertion mid-operation aborts any pending step or phase immediately.
- Debounce (per button):
  - Each button passes through a 2-flop synchroniser, then a counter.
  - The counter increments while the synchronised value differs from btn_level and clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, btn_level takes the synchronised value and the counter clears.
  - btn_pulse is high for exactly the one cycle after a 0->1 update of btn_level.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
  - Latency from a clean raw edge to the btn_level change is DEBOUNCE_CYCLES+2 cycles.
- Divider:
  - div counts 0..CE_DIV-1 and wraps. It runs freely in every state.
  - Raw cpu phase: div==CE_DIV-1. Raw mem phase: div==CE_DIV/2-1.
  - Both outputs are registered, so each appears one cycle after its raw phase.
- State machine (run_pulse = btn_pulse[0]):
  - IDLE:
    - run_pulse with mode_step=0 -> RUN.
    - run_pulse with mode_step=1 -> STEP.
    - No enables are issued in IDLE.
  - RUN:
    - cpu_ce and mem_ce are issued on every phase.
    - end_program=1 -> HALT. This takes priority over run_pulse.
    - Otherwise run_pulse -> IDLE (pause).
  - STEP:
    - Issues exactly one cpu_ce at the next cpu phase, followed by the one mem_ce at the next mem phase.
    - Returns to IDLE after that mem_ce.
    - end_program=1 at any point in STEP -> HALT after the current enable completes.
    - run_pulse in STEP is ignored.
  - HALT:
    - No enables. All button pulses are ignored.
    - Only RESET exits HALT.
- Enable gating:
  - An enable is issued only if the state permits it in the cycle of the raw phase.
  - A state change never produces a partial or duplicated enable.
- Counters and LEDs:
  - ce_count increments on each cpu_ce and holds at 16'hFFFF.
  - end_led sets on end_program=1 in any state and clears only on RESET.
  - cnt increments every cycle and wraps at 2^CNT_W.

Test Plan (DEBOUNCE_CYCLES=4, CE_DIV=4, HB_LSB=2, HB_BITS=3, NUM_BTN=2 unless stated):
1. Reset/heartbeat: release RESET and run 32 cycles.
   - Required: heartbeat steps 0,1,...,7 every 4 cycles and wraps to 0. All other outputs stay 0 and state stays IDLE.
2. Debounce: pulse btn_raw[1] high for 3 cycles.
   - Required: btn_level[1] stays 0.
   - Then hold it high: btn_level[1] rises exactly 6 cycles after the raw edge, and btn_pulse[1] is high for 1 cycle.
3. Free-run: mode_step=0, press run, let 40 cycles elapse, then press run again.
   - Required: cpu_ce every 4 cycles, mem_ce 2 cycles after each cpu_ce, state 1 then 0 after the second press.
   - ce_count equals the number of cpu_ce pulses seen (10 for a 40-cycle window).
4. Single-step: mode_step=1, press run 3 times with gaps of at least 20 cycles.
   - Required: exactly 3 cpu_ce and 3 mem_ce, ce_count=3, state returns to 0 after each step.
5. Halt priority: in RUN, assert end_program and run_pulse in the same cycle.
   - Required: state=3 and end_led=1, with no further enables.
   - A later run press has no effect. RESET returns state to 0 and end_led to 0.
6. Reset mid-step: assert RESET one cycle before a STEP cpu phase.
   - Required: no cpu_ce is issued, and all outputs read 0 on the next cycle.
